// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB4 bus bundle between a requester and the apb_slave_mem completer
// Signals: paddr/pprot/psel/penable/pwrite/pwdata/pstrb driven by the master;
//          pready/prdata/pslverr driven by the slave.
interface apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;
    modport master (output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, input pready, prdata, pslverr);
    modport slave (input paddr, pprot, psel, penable, pwrite, pwdata, pstrb, output pready, prdata, pslverr);
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer over a word memory with wait states, byte strobes and slave errors
// Ports: clk; reset (synchronous, active high); bus (APB slave side, pready/prdata/pslverr registered);
//        apb_abort (one-cycle pulse when a transfer is abandoned before completion)
module apb_slave_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 0,
    parameter bit                    RAND_WAIT   = 1'b0,
    parameter bit                    PROT_CHECK  = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    apb_slave_mem_if.slave bus,
    output logic           apb_abort
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BL = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [15:0] lfsr;
    logic [3:0] cnt, w;
    logic [IW-1:0] idx, a_idx;
    logic [ADDR_WIDTH-1:0] off;
    logic err, a_err, a_wr, setup, step, done, abort, unused_prot;
    assign off = bus.paddr - BASE_ADDR;
    assign err = (|(off & ADDR_WIDTH'(NB - 1))) | (off >= ADDR_WIDTH'(DEPTH * NB)) | (PROT_CHECK & ~bus.pprot[0]);
    assign idx = off[BL +: IW];
    assign w = RAND_WAIT ? 4'(lfsr % 16'(WAIT_CYCLES + 1)) : 4'(WAIT_CYCLES);
    assign unused_prot = ^bus.pprot[2:1];
    // A setup seen while a transfer is still open restarts it and counts as an abort of the old one.
    always_comb begin
        setup = bus.psel & ~bus.penable;
        step = (state == ACCESS) & bus.psel & bus.penable & ~bus.pready;
        done = (state == ACCESS) & bus.psel & bus.penable & bus.pready;
        abort = (state == ACCESS) & (~bus.psel | setup);
        state_n = setup ? ACCESS : (done | abort) ? IDLE : state;
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr        <= 16'hACE1;
            cnt         <= '0;
            a_idx       <= '0;
            a_wr        <= 1'b0;
            a_err       <= 1'b0;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= '0;
            apb_abort   <= 1'b0;
        end else begin
            apb_abort <= abort;
            if (setup) begin
                lfsr        <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
                cnt         <= w;
                a_idx       <= idx;
                a_wr        <= bus.pwrite;
                a_err       <= err;
                bus.pready  <= (w == 4'd0);
                bus.pslverr <= (w == 4'd0) & err;
                bus.prdata  <= ((w == 4'd0) & ~bus.pwrite & ~err) ? mem[idx] : '0;
            end else if (step) begin
                cnt         <= cnt - 4'd1;
                bus.pready  <= (cnt == 4'd1);
                bus.pslverr <= (cnt == 4'd1) & a_err;
                bus.prdata  <= ((cnt == 4'd1) & ~a_wr & ~a_err) ? mem[a_idx] : '0;
            end else if (done | abort) begin
                bus.pready  <= 1'b0;
                bus.pslverr <= 1'b0;
                bus.prdata  <= '0;
            end
        end
    end
    // Memory has no reset; a write landing on a reset edge is dropped.
    always_ff @(posedge clk)
        if (~reset & done & a_wr & ~a_err)
            for (int b = 0; b < NB; b++)
                if (bus.pstrb[b]) mem[a_idx][8*b +: 8] <= bus.pwdata[8*b +: 8];
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed scoreboard bench over four apb_slave_mem configurations
module tb_apb_slave_mem;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    int sel = 0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [2:0] pprot = 3'b001;
    logic [3:0] pstrb = '0;
    logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0] rdy_w, err_w, abt_w;
    logic [3:0][31:0] rd_w;
    typedef struct {logic [31:0] d; logic e;} exp_t;
    exp_t q[$];
    logic [31:0] mdl [4][256];
    int checks = 0, errors = 0;
    // Instance g: 0 = no waits, 1 = protection check, 2 = 3 fixed waits, 3 = 0..3 random waits.
    for (genvar g = 0; g < 4; g++) begin : u
        apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.paddr   = paddr;
        assign bus.pprot   = pprot;
        assign bus.psel    = psel && (sel == g);
        assign bus.penable = penable;
        assign bus.pwrite  = pwrite;
        assign bus.pwdata  = pwdata;
        assign bus.pstrb   = pstrb;
        assign rdy_w[g]    = bus.pready;
        assign err_w[g]    = bus.pslverr;
        assign rd_w[g]     = bus.prdata;
        apb_slave_mem #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0),
            .WAIT_CYCLES(g >= 2 ? 3 : 0), .RAND_WAIT(g == 3), .PROT_CHECK(g == 1)
        ) dut (
            .clk(clk), .reset(reset), .bus(bus), .apb_abort(abt_w[g])
        );
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Called #1 after a clock edge; returns #1 after the edge that completes the transfer, bus idle.
    task automatic xfer(input string tag, input int k, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [2:0] prot,
                        output int n, output logic [31:0] rd);
        exp_t x, y;
        bit e;
        e = (a[1:0] != 2'b00) || (a >= 32'h400) || (k == 1 && !prot[0]);
        sel = k; paddr = a; pwrite = wr; pwdata = d; pstrb = s; pprot = prot;
        psel = 1'b1; penable = 1'b0;
        x.e = e;
        x.d = (!wr && !e) ? mdl[k][a[9:2]] : 32'h0;
        q.push_back(x);
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        while (!rdy_w[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        y = q.pop_front();
        rd = rd_w[k];
        if (!rdy_w[k]) chk({tag, "_timeout"}, 64'(rdy_w[k]), 64'd1);
        else begin
            chk({tag, "_prdata"}, 64'(rd_w[k]), 64'(y.d));
            chk({tag, "_pslverr"}, 64'(err_w[k]), 64'(y.e));
            if (wr && !e)
                for (int b = 0; b < 4; b++)
                    if (s[b]) mdl[k][a[9:2]][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk({tag, "_pready_drop"}, 64'(rdy_w[k]), 64'd0);
    endtask
    initial begin
        int n, wfirst, pulses, bad;
        logic [31:0] r;
        bit [3:0] seen;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_pready", 64'(rdy_w[k]), 64'd0);
            chk("rst_pslverr", 64'(err_w[k]), 64'd0);
            chk("rst_prdata", 64'(rd_w[k]), 64'd0);
            chk("rst_abort", 64'(abt_w[k]), 64'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        // First random wait after reset: seed 0xACE1 % 4 = 1.
        xfer("rand_first", 3, 1, 32'h50, 32'h0BADCAFE, 4'hF, 3'b001, wfirst, r);
        chk("rand_first_w", 64'(wfirst), 64'd1);
        xfer("wr10", 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001, n, r);
        chk("wr10_waits", 64'(n), 64'd0);
        xfer("rd10", 0, 0, 32'h10, 32'h0, 4'h0, 3'b001, n, r);
        chk("rd10_waits", 64'(n), 64'd0);
        chk("rd10_value", 64'(r), 64'hDEADBEEF);
        xfer("wr20", 0, 1, 32'h20, 32'h11223344, 4'hF, 3'b001, n, r);
        xfer("wr20_strb", 0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 3'b001, n, r);
        xfer("rd20", 0, 0, 32'h20, 32'h0, 4'h0, 3'b001, n, r);
        chk("rd20_value", 64'(r), 64'h11BB33DD);
        xfer("rd400", 0, 0, 32'h400, 32'h0, 4'h0, 3'b001, n, r);
        chk("rd400_err", 64'(err_w[0]), 64'd0);
        xfer("wr402", 0, 1, 32'h402, 32'h55555555, 4'hF, 3'b001, n, r);
        xfer("wr12", 0, 1, 32'h12, 32'hFFFFFFFF, 4'hF, 3'b001, n, r);
        xfer("wr10_nostrb", 0, 1, 32'h10, 32'h0, 4'h0, 3'b001, n, r);
        xfer("rd10_again", 0, 0, 32'h10, 32'h0, 4'h0, 3'b001, n, r);
        chk("rd10_unchanged", 64'(r), 64'hDEADBEEF);
        xfer("prot_wr_bad", 1, 1, 32'h10, 32'h12121212, 4'hF, 3'b000, n, r);
        xfer("prot_wr_ok", 1, 1, 32'h10, 32'h5A5A5A5A, 4'hF, 3'b001, n, r);
        xfer("prot_rd_bad", 1, 0, 32'h10, 32'h0, 4'h0, 3'b000, n, r);
        xfer("prot_rd_ok", 1, 0, 32'h10, 32'h0, 4'h0, 3'b001, n, r);
        chk("prot_rd_value", 64'(r), 64'h5A5A5A5A);
        xfer("wait_wr30", 2, 1, 32'h30, 32'h12345678, 4'hF, 3'b001, n, r);
        chk("wait_wr_waits", 64'(n), 64'd3);
        // Abandon a write to 0x30 in its first wait state.
        sel = 2; paddr = 32'h30; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF; pprot = 3'b001;
        psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (abt_w[2]) pulses++;
        end
        chk("abort_pulses", 64'(pulses), 64'd1);
        xfer("abort_rd30", 2, 0, 32'h30, 32'h0, 4'h0, 3'b001, n, r);
        chk("abort_rd30_value", 64'(r), 64'h12345678);
        chk("abort_rd30_waits", 64'(n), 64'd3);
        seen = '0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            xfer("rand_rd50", 3, 0, 32'h50, 32'h0, 4'h0, 3'b001, n, r);
            if (n <= 3) seen[n] = 1'b1;
            else bad++;
        end
        chk("rand_range", 64'(bad), 64'd0);
        chk("rand_all_seen", 64'(seen), 64'hF);
        // Reset lands on the completion edge of a write: write dropped, LFSR reseeded.
        xfer("wr40", 0, 1, 32'h40, 32'h01020304, 4'hF, 3'b001, n, r);
        sel = 0; paddr = 32'h40; pwrite = 1'b1; pwdata = 32'hBBBBBBBB; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("pre_reset_pready", 64'(rdy_w[0]), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_pready", 64'(rdy_w[0]), 64'd0);
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        xfer("rd40", 0, 0, 32'h40, 32'h0, 4'h0, 3'b001, n, r);
        chk("rd40_value", 64'(r), 64'h01020304);
        xfer("rand_after_reset", 3, 0, 32'h50, 32'h0, 4'h0, 3'b001, n, r);
        chk("rand_reseed", 64'(n), 64'(wfirst));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
